// File: rtl/mem_arbiter_if.sv
// Interface bundling the arbiter's two requester ports and its memory port.
//   imem_*  : instruction fetch request/response (core side)
//   dmem_*  : load/store request/response (core side)
//   mem_*   : unified single-port memory request/response (bus side)
//   bus_err : watchdog abort indication, pulses together with a ready
// Modports:
//   slave  : the arbiter's view (takes requests, drives responses and the memory bus)
//   master : the environment's view (core + memory model)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_rd_addr;
  logic              imem_rd_enable;
  logic [DATA_W-1:0] imem_rd_data;
  logic              imem_rd_ready;

  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_r_enable;
  logic              dmem_w_enable;
  logic [1:0]        dmem_w_size;
  logic [DATA_W-1:0] dmem_w_data;
  logic [DATA_W-1:0] dmem_r_data;
  logic              dmem_ready;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              bus_err;

  modport slave (
    input  imem_rd_addr, imem_rd_enable,
    output imem_rd_data, imem_rd_ready,
    input  dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
    output dmem_r_data, dmem_ready,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output bus_err
  );

  modport master (
    output imem_rd_addr, imem_rd_enable,
    input  imem_rd_data, imem_rd_ready,
    output dmem_addr, dmem_r_enable, dmem_w_enable, dmem_w_size, dmem_w_data,
    input  dmem_r_data, dmem_ready,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// One transaction at a time: grant in IDLE, hold the bus in BUSY until mem_ack (or
// watchdog abort), pulse the requester's ready, then one RESP cycle before re-arbitrating.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : mem_arbiter_if slave modport (fetch, data and memory sides, bus_err)
// Parameters:
//   ADDR_W, DATA_W : must match the connected interface
//   TIMEOUT        : BUSY cycles without mem_ack before abort; 0 disables (max 65535)
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  localparam logic        GrantI      = 1'b0;
  localparam logic        GrantD      = 1'b1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [15:0]       wd_q, wd_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] imem_rd_data_q, imem_rd_data_d;
  logic              imem_rd_ready_q, imem_rd_ready_d;
  logic [DATA_W-1:0] dmem_r_data_q, dmem_r_data_d;
  logic              dmem_ready_q, dmem_ready_d;
  logic              bus_err_q, bus_err_d;

  logic              ireq, dreq, grant_d, grant_i, timed_out;

  assign ireq = bus.imem_rd_enable;
  assign dreq = bus.dmem_r_enable | bus.dmem_w_enable;
  // With both pending, the side that did not win last time goes next.
  assign grant_d = dreq & (~ireq | (last_grant_q == GrantI));
  assign grant_i = ireq & ~grant_d;
  assign timed_out = (TIMEOUT != 0) && (wd_q == TimeoutLast);

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wd_d            = wd_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_size_d      = mem_size_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    imem_rd_data_d  = imem_rd_data_q;
    dmem_r_data_d   = dmem_r_data_q;
    imem_rd_ready_d = 1'b0;
    dmem_ready_d    = 1'b0;
    bus_err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d      = StBusyD;
          last_grant_d = GrantD;
          wd_d         = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = bus.dmem_addr;
          mem_wdata_d  = bus.dmem_w_data;
          // A store wins over a load when both enables are high.
          mem_we_d     = bus.dmem_w_enable;
          mem_size_d   = bus.dmem_w_enable ? bus.dmem_w_size : 2'd2;
        end else if (grant_i) begin
          state_d      = StBusyI;
          last_grant_d = GrantI;
          wd_d         = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = bus.imem_rd_addr;
          mem_wdata_d  = '0;
          mem_we_d     = 1'b0;
          mem_size_d   = 2'd2;
        end
      end

      StBusyI, StBusyD: begin
        // An ack in the timeout cycle counts as a normal completion.
        if (bus.mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (state_q == StBusyI) begin
            imem_rd_data_d  = bus.mem_rdata;
            imem_rd_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) dmem_r_data_d = bus.mem_rdata;
            dmem_ready_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == StBusyI) begin
            imem_rd_data_d  = '0;
            imem_rd_ready_d = 1'b1;
          end else begin
            dmem_r_data_d = '0;
            dmem_ready_d  = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 16'd1;
        end
      end

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      last_grant_q    <= GrantI;
      wd_q            <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_size_q      <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      imem_rd_data_q  <= '0;
      imem_rd_ready_q <= 1'b0;
      dmem_r_data_q   <= '0;
      dmem_ready_q    <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wd_q            <= wd_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_size_q      <= mem_size_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      imem_rd_data_q  <= imem_rd_data_d;
      imem_rd_ready_q <= imem_rd_ready_d;
      dmem_r_data_q   <= dmem_r_data_d;
      dmem_ready_q    <= dmem_ready_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.imem_rd_data  = imem_rd_data_q;
  assign bus.imem_rd_ready = imem_rd_ready_q;
  assign bus.dmem_r_data   = dmem_r_data_q;
  assign bus.dmem_ready    = dmem_ready_q;
  assign bus.bus_err       = bus_err_q;

endmodule
